// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling layers: default bus widths, the pool
// FSM state type and a signed max helper.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    PoolIdle,
    PoolAccum,
    PoolDone
  } pool_state_e;

  // Pure selection: ties may return either operand, the value is the same.
  function automatic logic signed [DEF_DATA_W-1:0] smax(
    input logic signed [DEF_DATA_W-1:0] a,
    input logic signed [DEF_DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Half-width row buffer for 2x2 pooling: holds the horizontal maxima of the even
// row, one entry per output column. Synchronous write, combinational read.
module pool_row_buf #(
  parameter int unsigned Depth  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IdxW   = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [IdxW-1:0]          wr_idx,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [IdxW-1:0]          rd_idx,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/max_pool_1.sv
// 2x2 stride-2 signed max pooling over the first conv layer's streamed output.
// Optional macro POOL1_RELU_EN clamps negative pooled results to zero.
module max_pool_1
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IN_H   = 33,
  parameter int unsigned IN_W   = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     layer_enable,
  input  logic                     in_wr_en,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     out_wr_en,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     layer_done,
  output logic                     addr_err
);

  localparam int unsigned OUT_H = IN_H / 2;
  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned ROW_W = $clog2(IN_H + 1);
  localparam int unsigned COL_W = $clog2(IN_W + 1);
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IN_H - 1);
  localparam logic [COL_W-1:0] ColLast = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] RowLim  = ROW_W'(2 * OUT_H);
  localparam logic [COL_W-1:0] ColLim  = COL_W'(2 * OUT_W);
  // With even dimensions the final word also completes a window, so the done
  // pulse waits one extra cycle to land after that last strobe.
  localparam bit LastInWindow = ((IN_H % 2) == 0) && ((IN_W % 2) == 0);

  pool_state_e state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ADDR_W-1:0]        exp_q, exp_d;
  logic [ADDR_W-1:0]        ocnt_q, ocnt_d;
  logic signed [DATA_W-1:0] hmax_q, hmax_d;
  logic                     owr_q, owr_d;
  logic signed [DATA_W-1:0] odata_q, odata_d;
  logic [ADDR_W-1:0]        oaddr_q, oaddr_d;
  logic                     done_q, done_d;
  logic                     pend_q, pend_d;
  logic                     err_q, err_d;

  logic                     accept, in_rng, last_word, rb_we;
  logic [IDX_W-1:0]         col_half;
  logic signed [DATA_W-1:0] win_m, rb_rd, pooled;

  assign col_half = IDX_W'(col_q >> 1);

  pool_row_buf #(
    .Depth  (OUT_W),
    .DATA_W (DATA_W),
    .IdxW   (IDX_W)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (rb_we),
    .wr_idx  (col_half),
    .wr_data (win_m),
    .rd_idx  (col_half),
    .rd_data (rb_rd)
  );

  always_comb begin
    accept    = (state_q == PoolAccum) && layer_enable && in_wr_en;
    in_rng    = (row_q < RowLim) && (col_q < ColLim);
    last_word = (row_q == RowLast) && (col_q == ColLast);
    win_m     = smax(hmax_q, in_data);
    pooled    = smax(rb_rd, win_m);
`ifdef POOL1_RELU_EN
    if (pooled[DATA_W-1]) begin
      pooled = '0;
    end
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PoolIdle:  if (layer_enable) state_d = PoolAccum;
      PoolAccum: begin
        if (!layer_enable) begin
          state_d = PoolIdle;
        end else if (accept && last_word) begin
          state_d = PoolDone;
        end
      end
      PoolDone:  if (!layer_enable) state_d = PoolIdle;
      default:   state_d = PoolIdle;
    endcase
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    exp_d   = exp_q;
    ocnt_d  = ocnt_q;
    hmax_d  = hmax_q;
    owr_d   = 1'b0;
    odata_d = odata_q;
    oaddr_d = oaddr_q;
    done_d  = 1'b0;
    pend_d  = 1'b0;
    err_d   = err_q;
    rb_we   = 1'b0;

    if (state_q == PoolIdle) begin
      row_d  = '0;
      col_d  = '0;
      exp_d  = '0;
      ocnt_d = '0;
      if (layer_enable) err_d = 1'b0;
    end

    if (accept) begin
      if (in_addr != exp_q) err_d = 1'b1;
      exp_d = exp_q + ADDR_W'(1);
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Words in a dropped trailing row/column only advance the counters.
      if (in_rng) begin
        if (!col_q[0]) begin
          hmax_d = in_data;
        end else if (!row_q[0]) begin
          rb_we = 1'b1;
        end else begin
          owr_d   = 1'b1;
          odata_d = pooled;
          oaddr_d = ocnt_q;
          ocnt_d  = ocnt_q + ADDR_W'(1);
        end
      end
      if (last_word) begin
        if (LastInWindow) pend_d = 1'b1;
        else              done_d = 1'b1;
      end
    end

    if ((state_q == PoolDone) && in_wr_en) err_d = 1'b1;
    if (pend_q && layer_enable) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PoolIdle;
      row_q   <= '0;
      col_q   <= '0;
      exp_q   <= '0;
      ocnt_q  <= '0;
      hmax_q  <= '0;
      owr_q   <= 1'b0;
      odata_q <= '0;
      oaddr_q <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      exp_q   <= exp_d;
      ocnt_q  <= ocnt_d;
      hmax_q  <= hmax_d;
      owr_q   <= owr_d;
      odata_q <= odata_d;
      oaddr_q <= oaddr_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign out_wr_en  = owr_q;
  assign out_data   = odata_q;
  assign out_addr   = oaddr_q;
  assign layer_done = done_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_max_pool_1.sv
// Self-checking bench for max_pool_1: table-driven windows, ramp/random frames
// against a frame-level pooling model, gaps, address errors, abort and reset.
module tb_max_pool_1;

  localparam int IH = 33;
  localparam int IW = 33;
  localparam int OH = IH / 2;
  localparam int OW = IW / 2;
  localparam int NW = IH * IW;
  localparam int NO = OH * OW;
`ifdef POOL1_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        layer_enable = 1'b0;
  logic        in_wr_en = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] in_addr = '0;
  logic        out_wr_en;
  logic [15:0] out_data;
  logic [15:0] out_addr;
  logic        layer_done;
  logic        addr_err;

  always #5 clk = ~clk;

  max_pool_1 dut (
    .clk          (clk),
    .rst          (rst),
    .layer_enable (layer_enable),
    .in_wr_en     (in_wr_en),
    .in_data      (in_data),
    .in_addr      (in_addr),
    .out_wr_en    (out_wr_en),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .layer_done   (layer_done),
    .addr_err     (addr_err)
  );

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;
  int fr [IH][IW];
  int drv_cyc [NW];
  int ob_data[$];
  int ob_addr[$];
  int ob_cyc[$];
  int done_cyc[$];
  int total_done = 0;

  typedef struct {
    int a, b, c, d;
    int want;
    int fill;
  } vec_t;
  vec_t tv [6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_wr_en) begin
      ob_data.push_back(int'($signed(out_data)));
      ob_addr.push_back(int'(out_addr));
      ob_cyc.push_back(cyc);
    end
    if (layer_done) begin
      done_cyc.push_back(cyc);
      total_done++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic int clamp(input int v);
    return (Relu && v < 0) ? 0 : v;
  endfunction

  // Reference: max over the 2x2 window of the stored frame.
  function automatic int ref_pool(input int k);
    int orow = k / OW;
    int ocol = k % OW;
    int m = fr[2*orow][2*ocol];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (fr[2*orow+dr][2*ocol+dc] > m) m = fr[2*orow+dr][2*ocol+dc];
    return clamp(m);
  endfunction

  function automatic int win_idx(input int k);
    return (2 * (k / OW) + 1) * IW + 2 * (k % OW) + 1;
  endfunction

  function automatic int qget(input int idx);
    return (idx < ob_data.size()) ? ob_data[idx] : -99999;
  endfunction

  task automatic fill(input int mode, input int val);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        case (mode)
          0:       fr[r][c] = r * IW + c + 1;
          1:       fr[r][c] = int'($urandom_range(65535)) - 32768;
          default: fr[r][c] = val;
        endcase
  endtask

  task automatic drive_word(input int i, input int addr);
    @(negedge clk);
    in_wr_en = 1'b1;
    in_data  = 16'(fr[i/IW][i%IW]);
    in_addr  = 16'(addr);
    drv_cyc[i] = cyc;
  endtask

  task automatic feed(input bit gap, input int bad_pos, input int stop_at);
    ob_data.delete();
    ob_addr.delete();
    ob_cyc.delete();
    done_cyc.delete();
    @(negedge clk);
    layer_enable = 1'b1;
    in_wr_en = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (i == stop_at) break;
      if (gap && i > 0) begin
        @(negedge clk);
        in_wr_en = 1'b0;
      end
      drive_word(i, (i == bad_pos) ? i + 1 : i);
    end
    @(negedge clk);
    in_wr_en = 1'b0;
    if (stop_at >= 0) layer_enable = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    layer_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int nwords, input int exp_err);
    int n_exp = 0;
    int n;
    for (int k = 0; k < NO; k++) if (win_idx(k) < nwords) n_exp++;
    chk({tag, " strobe count"}, ob_data.size(), n_exp);
    n = (ob_data.size() < n_exp) ? ob_data.size() : n_exp;
    for (int j = 0; j < n; j++) begin
      chk({tag, " out_addr"}, ob_addr[j], j);
      chk({tag, " out_data"}, ob_data[j], ref_pool(j));
      chk({tag, " strobe latency"}, ob_cyc[j], drv_cyc[win_idx(j)] + 1);
    end
    chk({tag, " layer_done count"}, done_cyc.size(), (nwords == NW) ? 1 : 0);
    if (nwords == NW && done_cyc.size() == 1)
      chk({tag, " layer_done timing"}, done_cyc[0], drv_cyc[NW-1] + 1);
    chk({tag, " addr_err"}, int'(addr_err), exp_err);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " out_wr_en"}, int'(out_wr_en), 0);
    chk({tag, " out_data"}, int'(out_data), 0);
    chk({tag, " out_addr"}, int'(out_addr), 0);
    chk({tag, " layer_done"}, int'(layer_done), 0);
    chk({tag, " addr_err"}, int'(addr_err), 0);
  endtask

  initial begin
    tv[0] = '{-3, -7, -1, -9, -1, -5};
    tv[1] = '{5, -2, 7, 3, 7, -5};
    tv[2] = '{-32768, -32768, -32768, -32768, -32768, -5};
    tv[3] = '{32767, -32768, 0, 1, 32767, -5};
    tv[4] = '{100, 100, 100, 100, 100, -1};
    tv[5] = '{-2, -2, -3, -2, -2, 0};

    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp frame, back-to-back
    fill(0, 0);
    feed(1'b0, -1, -1);
    check_frame("ramp", NW, 0);
    chk("ramp addr0", qget(0), 35);
    chk("ramp addr1", qget(1), 37);
    chk("ramp addr16", qget(16), 101);
    chk("ramp addr255", qget(255), 1055);
    // Stray word while in DONE must flag addr_err and produce nothing
    @(negedge clk);
    in_wr_en = 1'b1;
    @(negedge clk);
    in_wr_en = 1'b0;
    @(negedge clk);
    chk("done stray addr_err", int'(addr_err), 1);
    chk("done stray strobes", ob_data.size(), NO);
    end_frame();

    // Table-driven single-window vectors over a constant background
    for (int t = 0; t < 6; t++) begin
      fill(2, tv[t].fill);
      fr[0][0] = tv[t].a;
      fr[0][1] = tv[t].b;
      fr[1][0] = tv[t].c;
      fr[1][1] = tv[t].d;
      feed(1'b0, -1, -1);
      check_frame("table", NW, 0);
      chk("table window", qget(0), clamp(tv[t].want));
      chk("table fill", qget(1), clamp(tv[t].fill));
      end_frame();
    end

    // Random frames
    for (int t = 0; t < 2; t++) begin
      fill(1, 0);
      feed(1'b0, -1, -1);
      check_frame("random", NW, 0);
      end_frame();
    end

    // Gapped ramp
    fill(0, 0);
    feed(1'b1, -1, -1);
    check_frame("gapped", NW, 0);
    end_frame();

    // Address error: word 40 carries the wrong address
    fill(1, 0);
    feed(1'b0, 40, -1);
    check_frame("addrerr", NW, 1);
    end_frame();
    chk("addrerr sticky idle", int'(addr_err), 1);
    @(negedge clk);
    layer_enable = 1'b1;
    @(negedge clk);
    chk("addrerr cleared", int'(addr_err), 0);
    end_frame();

    // Mid-frame abort, then full rerun
    fill(0, 0);
    feed(1'b0, -1, 500);
    check_frame("abort", 500, 0);
    end_frame();
    feed(1'b0, -1, -1);
    check_frame("rerun", NW, 0);
    end_frame();

    // Asynchronous reset during a strobe
    fill(1, 0);
    ob_data.delete();
    @(negedge clk);
    layer_enable = 1'b1;
    for (int i = 0; i <= 64; i++) drive_word(i, i);
    @(posedge clk);
    #1;
    chk("pre-reset strobe", int'(out_wr_en), 1);
    chk("pre-reset data", int'($signed(out_data)), ref_pool(15));
    chk("pre-reset addr", int'(out_addr), 15);
    rst = 1'b1;
    #1;
    chk_outputs_zero("async reset");
    in_wr_en = 1'b0;
    layer_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back frames
    total_done = 0;
    for (int t = 0; t < 2; t++) begin
      fill(1, 0);
      feed(1'b0, -1, -1);
      check_frame("b2b", NW, 0);
      end_frame();
    end
    chk("b2b done pulses", total_done, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/max_pool_1.md
Name: max_pool_1

Overview:
- First pooling stage; sits directly downstream of the first 2D convolution layer.
- Consumes the convolution's streamed result bus (data, linear address, write strobe) in row-major order.
- Performs 2x2 stride-2 signed max pooling and streams pooled results, with a sequential output address, to the next layer.
- Uses a half-width row buffer. It stores no full frame.

Parameters:
- DATA_W, 16, width of the signed fixed-point data word.
- ADDR_W, 16, width of the input and output address buses.
- IN_H, 33, conv output rows per frame.
- IN_W, 33, conv output columns per frame.
- Derived localparams: OUT_H = IN_H/2 and OUT_W = IN_W/2 (floor). An odd last row or column is dropped.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- layer_enable  in  1  high for the duration of a frame; low means idle or clear.
- in_wr_en  in  1  input word valid this cycle.
- in_data  in  DATA_W  signed conv result.
- in_addr  in  ADDR_W  linear row-major address of in_data.
- out_wr_en  out  1  pooled word valid, one-cycle strobe.
- out_data  out  DATA_W  signed pooled max.
- out_addr  out  ADDR_W  pooled linear address, 0 to OUT_H*OUT_W-1.
- layer_done  out  1  one-cycle pulse after the last pooled word.
- addr_err  out  1  sticky: an input address did not match the expected sequence.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; clock and reset are named clk and rst.
  - All outputs reset to 0. State resets to IDLE. Counters, h_max and addr_err reset to 0.
  - The row buffer contents are don't-care after reset.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_wr_en is ignored; counters are held at 0. On layer_enable=1, clear addr_err and go to ACCUM.
  - ACCUM: process each in_wr_en word. Gaps in in_wr_en are allowed and there is no backpressure. After the final input word (row IN_H-1, col IN_W-1), go to DONE.
  - DONE: assert layer_done for exactly one cycle in the first DONE cycle, then stay until layer_enable=0, then go to IDLE.
  - layer_enable=0 in any state returns to IDLE on the next edge and abandons the partial frame. No further out_wr_en is produced.
- Counters:
  - Internal row and col counters advance on each accepted word; col wraps at IN_W-1 and row increments on the wrap.
  - Expected address = row*IN_W+col, kept as a running counter with no multiplier.
  - If in_wr_en and in_addr differs from the expected address, set addr_err=1. The word is still processed at the counter position.
- Datapath, on accepted words with row < 2*OUT_H and col < 2*OUT_W:
  - col even: h_max <= in_data.
  - col odd: m = signed max(h_max, in_data).
    - If row is even: rowbuf[col>>1] <= m.
    - If row is odd: on the next cycle, out_data = signed max(rowbuf[col>>1], m), out_wr_en=1, and out_addr = output counter; the output counter then increments.
  - Words in a dropped odd last row or column update the counters only.
- Timing and arithmetic:
  - Latency: out_wr_en is asserted exactly 1 cycle after the odd-row, odd-col input that completes a window.
  - layer_done fires the cycle after the last out_wr_en, or after the final input word when a trailing row or column is dropped.
  - All compares are signed two's complement at DATA_W. Max is pure selection, so no width growth occurs.
- Boundary cases:
  - An in_wr_en that arrives in DONE is ignored and sets addr_err.
  - When equal values are compared, either operand may be chosen; the result is identical.

Optional Feature:
- Macro: POOL1_RELU_EN.
  - Defined: out_data is clamped to 0 when the pooled max is negative, with no added latency.
  - Undefined: out_data is the raw signed max.

Decomposition:
- Shared package (cnn_pkg):
  - DATA_W and ADDR_W defaults.
  - The pool FSM state enum.
  - A signed max function reused by later pooling layers.
- Natural sub-module: pool_row_buf, an OUT_W x DATA_W register file with a synchronous write port and a combinational read port indexed by col>>1.

Test Plan:
1. Ramp frame:
   - Stimulus: rst pulse, layer_enable=1, feed 33x33 words in_data=r*33+c+1 with in_addr=r*33+c, back-to-back.
   - Required: 256 strobes; out_addr 0 gives 35, addr 1 gives 37, addr 16 gives 101, addr 255 gives 1055.
   - Required: layer_done pulses once; addr_err=0.
2. Negative data:
   - Stimulus: all in_data=-5 (0xFFFB).
   - Required: out_data=0xFFFB without POOL1_RELU_EN and 0x0000 with it; window {-3,-7,-1,-9} gives -1, or 0 with ReLU.
3. Gapped input:
   - Stimulus: ramp frame with in_wr_en low every other cycle.
   - Required: identical output values and addresses to scenario 1, each strobe 1 cycle after its completing input.
4. Address error:
   - Stimulus: skip in_addr 40.
   - Required: addr_err=1 and sticky; it clears on the next layer_enable rise after IDLE.
5. Mid-frame abort and reset:
   - Stimulus: drop layer_enable after 500 words, then rerun the full ramp.
   - Required: no strobes after the abort; the rerun matches scenario 1. rst asserted mid-frame forces all outputs to 0 immediately.
6. Back-to-back frames:
   - Stimulus: two frames separated by layer_enable low.
   - Required: out_addr restarts at 0; exactly two layer_done pulses.
